fifo_insert_arbiter: RTL

- Shares the write side of one 8-bit FIFO between NREQ producers.
- Each producer uses a req/ack handshake. A winner is picked each cycle by round-robin.
- The block drives the FIFO's insert, data_in and flush pins with registered outputs.
- It keeps an internal credit count of FIFO occupancy, including the write still in flight, so it never over-fills the FIFO despite the one-cycle output register.

---
 rtl/fifo_insert_arbiter_pkg.sv | 19 +
 rtl/fifo_insert_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_insert_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_insert_arbiter_pkg.sv
// Shared constants and helpers for the FIFO insert arbiter.
// Default sizes here must match the FIFO instance behind the arbiter.
package fifo_insert_arbiter_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int CNT_W     = clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/fifo_insert_arbiter_rr_pick.sv
// Combinational pick: first eligible index at or after ptr, wrapping.
// Returns a one-hot grant, its index and a valid flag.
module fifo_insert_arbiter_rr_pick
    import fifo_insert_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int PW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int p;
            logic [PW-1:0] pi;
            p = int'(ptr) + k;
            if (p >= NREQ) begin
                p = p - NREQ;
            end
            pi = PW'(p);
            if (!valid && eligible[pi]) begin
                valid     = 1'b1;
                grant[pi] = 1'b1;
                idx       = pi;
            end
        end
    end

endmodule

// File: rtl/fifo_insert_arbiter.sv
// Arbitrates NREQ producers onto one FIFO write port with credit tracking.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority (no pointer).
module fifo_insert_arbiter
    import fifo_insert_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                    ck,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    input  logic                    flush_req,
    input  logic                    pop,
    input  logic                    fifo_full,
    output logic                    fifo_insert,
    output logic [WIDTH-1:0]        fifo_data,
    output logic                    fifo_flush
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(NREQ);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(NREQ - 1);

    logic [NREQ-1:0]  ack_q, ack_d;
    logic             insert_q, insert_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             flush_q, flush_d;
    logic             hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  pick_oh;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    ptr_cur;
    logic             pick_valid;
    logic             grant;
    logic             dec;

`ifdef ARB_FIXED_PRIO_EN
    assign ptr_cur = '0;
`else
    logic [PW-1:0] ptr_q, ptr_d;
    assign ptr_cur = ptr_q;
`endif

    // Masking the current ack stops a held req from winning twice.
    assign eligible = req & ~ack_q;

    fifo_insert_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_cur),
        .grant    (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        grant = pick_valid && (cnt_q < CNT_MAX) && !fifo_full
                && !flush_req && !hold_q;
        dec      = pop && (cnt_q != '0);
        ack_d    = grant ? pick_oh : '0;
        insert_d = grant;
        data_d   = data_q;
        if (grant) begin
            data_d = req_data[int'(pick_idx)*WIDTH +: WIDTH];
        end
        flush_d = flush_req;
        hold_d  = flush_req;
        // Pops around a flush refer to entries the flush discards.
        if (flush_req) begin
            cnt_d = '0;
        end else if (hold_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(grant) - CW'(dec);
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (pick_idx == LAST) ? '0 : pick_idx + PW'(1);
        end
    end
`endif

    always_ff @(posedge ck) begin
        if (!reset) begin
            ack_q    <= '0;
            insert_q <= 1'b0;
            data_q   <= '0;
            flush_q  <= 1'b0;
            hold_q   <= 1'b0;
            cnt_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            ack_q    <= ack_d;
            insert_q <= insert_d;
            data_q   <= data_d;
            flush_q  <= flush_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign fifo_insert = insert_q;
    assign fifo_data   = data_q;
    assign fifo_flush  = flush_q;

endmodule
